// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Multi-cycle arithmetic sequencer between CPU issue and writeback. A single
//   16-bit adder/subtractor is time-shared to execute ADD, SUB, unsigned
//   shift-add MUL (16x16->32) and unsigned restoring DIV (quotient/remainder).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   command valid
//   in_ready   out  controller idle, command can be accepted
//   op         in   00 ADD, 01 SUB, 10 MUL, 11 DIV
//   a          in   operand A / multiplicand / dividend
//   b          in   operand B / multiplier / divisor
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   res_lo     out  sum/difference, product[15:0] or quotient
//   res_hi     out  0 for ADD/SUB, product[31:16] or remainder
//   ovf        out  ADD/SUB signed overflow, MUL product > 16 bits, DIV 0
//   dz         out  DIV with b == 0
//   busy       out  controller not idle
// ---------------------------------------------------------------------------

// 16-bit adder/subtractor: s = a + b (m=0) or a - b (m=1); f = signed overflow.
// Its carry-out is not exported; the sequencer reconstructs it from sign bits.
module adder_subtractor16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        m,
    output logic [15:0] s,
    output logic        f
);
    logic [15:0] b_x;

    assign b_x = b ^ {16{m}};
    assign s   = a + b_x + {15'd0, m};
    assign f   = (a[15] == b_x[15]) && (s[15] != a[15]);
endmodule

module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             ovf,
    output logic             dz,
    output logic             busy
);
    generate
        if (WIDTH != 16) begin : g_width_check
            $error("alu_seq_ctrl: WIDTH must be 16 to match the adder/subtractor");
        end
    endgenerate

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Unsigned carry of an addition, rebuilt from the operand and sum MSBs.
    function automatic logic add_carry(input logic a15, input logic b15, input logic s15);
        return (a15 & b15) | ((a15 ^ b15) & ~s15);
    endfunction

    // Unsigned A >= B of a subtraction, rebuilt from the operand and difference MSBs.
    function automatic logic sub_no_borrow(input logic a15, input logic b15, input logic s15);
        return (a15 & ~b15) | (~(a15 ^ b15) & ~s15);
    endfunction

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [4:0]       cnt;
    // acc_hi: P_hi (MUL) or R (DIV); acc_lo: P_lo/multiplier (MUL), Q (DIV),
    // or operand A (ADD/SUB, DIV-by-zero dividend); opnd: multiplicand/divisor/B.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_m;
    logic [WIDTH-1:0] add_s;
    logic             add_f;

    logic             mul_c;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic             div_take;
    logic [WIDTH-1:0] div_hi_nxt;
    logic [WIDTH-1:0] div_lo_nxt;
    logic [WIDTH-1:0] iter_hi_nxt;
    logic [WIDTH-1:0] iter_lo_nxt;

    adder_subtractor16 u_addsub (
        .a (add_a),
        .b (add_b),
        .m (add_m),
        .s (add_s),
        .f (add_f)
    );

    // Adder operand steering: EXEC uses A op B directly; MUL iterations add
    // the multiplicand to P_hi; DIV iterations trial-subtract the divisor from
    // the left-shifted partial remainder.
    always_comb begin
        add_a = acc_lo;
        add_b = opnd;
        add_m = op_r[0];
        if (state == ITER) begin
            if (op_r == OP_MUL) begin
                add_a = acc_hi;
                add_m = 1'b0;
            end else begin
                add_a = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                add_m = 1'b1;
            end
        end
    end

    always_comb begin
        // MUL: conditionally add, then shift {c, P_hi, P_lo} right by one.
        mul_c      = add_carry(add_a[WIDTH-1], add_b[WIDTH-1], add_s[WIDTH-1]);
        mul_hi_nxt = acc_lo[0] ? {mul_c, add_s[WIDTH-1:1]} : {1'b0, acc_hi[WIDTH-1:1]};
        mul_lo_nxt = {(acc_lo[0] ? add_s[0] : acc_hi[0]), acc_lo[WIDTH-1:1]};

        // DIV: acc_hi[MSB] is the bit shifted into r_ext; when set, the
        // 17-bit remainder is certainly >= divisor, so the subtract is taken.
        div_take   = acc_hi[WIDTH-1] |
                     sub_no_borrow(add_a[WIDTH-1], add_b[WIDTH-1], add_s[WIDTH-1]);
        div_hi_nxt = div_take ? add_s : add_a;
        div_lo_nxt = {acc_lo[WIDTH-2:0], div_take};

        iter_hi_nxt = (op_r == OP_MUL) ? mul_hi_nxt : div_hi_nxt;
        iter_lo_nxt = (op_r == OP_MUL) ? mul_lo_nxt : div_lo_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= OP_ADD;
            cnt    <= 5'd0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            res_lo <= '0;
            res_hi <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        cnt    <= 5'd0;
                        acc_hi <= '0;
                        if (op == OP_MUL) begin
                            acc_lo <= b;
                            opnd   <= a;
                        end else begin
                            acc_lo <= a;
                            opnd   <= b;
                        end
                        // Only MUL and DIV with a non-zero divisor iterate.
                        if (op == OP_MUL || (op == OP_DIV && b != '0))
                            state <= ITER;
                        else
                            state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= DONE;
                    if (op_r == OP_DIV) begin
                        res_lo <= '1;
                        res_hi <= acc_lo;
                        ovf    <= 1'b0;
                        dz     <= 1'b1;
                    end else begin
                        res_lo <= add_s;
                        res_hi <= '0;
                        ovf    <= add_f;
                        dz     <= 1'b0;
                    end
                end
                ITER: begin
                    acc_hi <= iter_hi_nxt;
                    acc_lo <= iter_lo_nxt;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state  <= DONE;
                        res_lo <= iter_lo_nxt;
                        res_hi <= iter_hi_nxt;
                        ovf    <= (op_r == OP_MUL) && (iter_hi_nxt != '0);
                        dz     <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl: a table of commands with hand-computed
//   results and latencies, followed by backpressure and mid-operation reset
//   sequences.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        ovf;
    logic        dz;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    alu_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .ovf       (ovf),
        .dz        (dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready)
            assert (!$isunknown(op)) else $error("op is X at accept");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a command from a negedge, wait (bounded) for in_ready, and
    // release in_valid just after the accepting edge.
    task automatic issue(input string tag, input logic [1:0] o,
                         input logic [15:0] x, input logic [15:0] y);
        int w;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count accept-to-out_valid edges; caller is positioned #1 after accept.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        issue(tag, v.op, v.a, v.b);
        wait_result(lat);
        chk({tag, "_lat"}, lat,               v.lat);
        chk({tag, "_lo"},  {16'd0, res_lo},   {16'd0, v.lo});
        chk({tag, "_hi"},  {16'd0, res_hi},   {16'd0, v.hi});
        chk({tag, "_ovf"}, {31'd0, ovf},      {31'd0, v.ovf});
        chk({tag, "_dz"},  {31'd0, dz},       {31'd0, v.dz});
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        vec_t v;

        //            op      a         b         lo        hi        ovf   dz    lat
        vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1};
        vecs[1]  = '{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1};
        vecs[3]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1};
        vecs[4]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 16};
        vecs[5]  = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 16};
        vecs[6]  = '{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0, 16};
        vecs[7]  = '{OP_DIV, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0, 1'b0, 16};
        vecs[8]  = '{OP_DIV, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 1'b0, 16};
        vecs[9]  = '{OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1};
        vecs[10] = '{OP_DIV, 16'h0007, 16'h0009, 16'h0000, 16'h0007, 1'b0, 1'b0, 16};
        vecs[11] = '{OP_SUB, 16'h1000, 16'h0FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = OP_ADD; a = '0; b = '0;

        // Reset state
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_res",       {res_hi, res_lo},   32'd0);
        chk("rst_flags",     {30'd0, ovf, dz},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // Backpressure: MUL result held for 10 cycles while an ADD waits.
        out_ready = 1'b0;
        issue("bp_mul", OP_MUL, 16'h0003, 16'h0005);
        wait_result(lat);
        chk("bp_mul_lat", lat, 16);
        op = OP_ADD; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res",   {res_hi, res_lo},   32'h0000_000F);
            chk("bp_hold_flags", {30'd0, ovf, dz},   32'd0);
            chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk);
        #1;
        chk("bp_pending_accepted", {30'd0, in_ready, busy}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_add_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_add_res",   {res_hi, res_lo},   32'h0000_0003);
        @(posedge clk);
        #1;

        // Reset during iteration 7 of a DIV.
        issue("rst_div", OP_DIV, 16'hFFFF, 16'h0003);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_busy",      {31'd0, busy},      32'd0);
        chk("mid_rst_res",       {res_hi, res_lo},   32'd0);
        chk("mid_rst_flags",     {30'd0, ovf, dz},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
        v = '{OP_ADD, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1};
        run_vec("post_rst_add", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
